// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared constants for the fetch/data memory bus arbiter: FSM state
//   encoding, enable/boolean literals, the zero word and the full byte-lane
//   select for the default 32-bit bus.
package mem_bus_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEL_W  = DEF_DATA_W / 8;

  // Arbiter FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_BUSY = 3'd1,
    I_BUSY = 3'd2,
    D_DONE = 3'd3,
    I_DONE = 3'd4
  } arb_state_e;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic True        = 1'b1;
  localparam logic False       = 1'b0;

  localparam logic [DEF_DATA_W-1:0] ZeroWord = '0;
  localparam logic [DEF_SEL_W-1:0]  FULL_SEL = '1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   External SoC memory bus seen by the arbiter.
//   master modport (arbiter side):
//     out bus_req_out, bus_we_out, bus_sel_out, bus_addr_out, bus_wdata_out
//     in  bus_rdata_in (valid with ack), bus_ack_in (one-cycle completion pulse)
//   slave modport: the mirror image, for the memory/bus fabric side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              bus_req_out;
  logic              bus_we_out;
  logic [SEL_W-1:0]  bus_sel_out;
  logic [ADDR_W-1:0] bus_addr_out;
  logic [DATA_W-1:0] bus_wdata_out;
  logic [DATA_W-1:0] bus_rdata_in;
  logic              bus_ack_in;

  modport master (
    output bus_req_out, bus_we_out, bus_sel_out, bus_addr_out, bus_wdata_out,
    input  bus_rdata_in, bus_ack_in
  );

  modport slave (
    input  bus_req_out, bus_we_out, bus_sel_out, bus_addr_out, bus_wdata_out,
    output bus_rdata_in, bus_ack_in
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one word-wide memory bus between the instruction-fetch port and
//   the load/store port. Data accesses win when both ask in the same cycle.
//   One transaction at a time; completed results are held while the
//   pipeline is stalled.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall_in, flush_in        pipeline stall / flush
//   inst_ce_in, inst_addr_in  fetch request; inst_data_out, stallreq_inst_out
//   data_ce_in/we/sel/addr/wdata  load/store request;
//   data_rdata_out, stallreq_data_out
//   bus                       memory bus (master modport)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic                inst_ce_in,
  input  logic [ADDR_W-1:0]   inst_addr_in,
  output logic [DATA_W-1:0]   inst_data_out,
  output logic                stallreq_inst_out,
  input  logic                data_ce_in,
  input  logic                data_we_in,
  input  logic [DATA_W/8-1:0] data_sel_in,
  input  logic [ADDR_W-1:0]   data_addr_in,
  input  logic [DATA_W-1:0]   data_wdata_in,
  output logic [DATA_W-1:0]   data_rdata_out,
  output logic                stallreq_data_out,
  mem_bus_arbiter_if.master   bus
);

  localparam int SEL_W = DATA_W / 8;
  // Clears the byte-offset bits so every bus address is word aligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(SEL_W - 1);

  arb_state_e        state_reg, state_next;
  logic              drop_reg, drop_next;
  logic              bus_req_reg, bus_req_next;
  logic              bus_we_reg, bus_we_next;
  logic [SEL_W-1:0]  bus_sel_reg, bus_sel_next;
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
  logic [DATA_W-1:0] inst_data_reg, inst_data_next;
  logic [DATA_W-1:0] data_rdata_reg, data_rdata_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      drop_reg       <= False;
      bus_req_reg    <= ChipDisable;
      bus_we_reg     <= False;
      bus_sel_reg    <= '0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      inst_data_reg  <= '0;
      data_rdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      drop_reg       <= drop_next;
      bus_req_reg    <= bus_req_next;
      bus_we_reg     <= bus_we_next;
      bus_sel_reg    <= bus_sel_next;
      bus_addr_reg   <= bus_addr_next;
      bus_wdata_reg  <= bus_wdata_next;
      inst_data_reg  <= inst_data_next;
      data_rdata_reg <= data_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    drop_next       = drop_reg;
    bus_req_next    = bus_req_reg;
    bus_we_next     = bus_we_reg;
    bus_sel_next    = bus_sel_reg;
    bus_addr_next   = bus_addr_reg;
    bus_wdata_next  = bus_wdata_reg;
    inst_data_next  = inst_data_reg;
    data_rdata_next = data_rdata_reg;

    case (state_reg)
      IDLE: begin
        // A flush cycle never launches a new access.
        if (!flush_in) begin
          if (data_ce_in == ChipEnable) begin
            bus_req_next   = ChipEnable;
            bus_we_next    = data_we_in;
            bus_sel_next   = data_sel_in;
            bus_addr_next  = data_addr_in & ALIGN_MASK;
            bus_wdata_next = data_wdata_in;
            state_next     = D_BUSY;
          end else if (inst_ce_in == ChipEnable) begin
            bus_req_next   = ChipEnable;
            bus_we_next    = False;
            bus_sel_next   = '1;
            bus_addr_next  = inst_addr_in & ALIGN_MASK;
            bus_wdata_next = '0;
            state_next     = I_BUSY;
          end
        end
      end

      // A load/store already on the bus always completes, flush or not.
      D_BUSY: begin
        if (bus.bus_ack_in) begin
          bus_req_next = ChipDisable;
          bus_we_next  = False;
          bus_sel_next = '0;
          if (!bus_we_reg) begin
            data_rdata_next = bus.bus_rdata_in;
          end
          state_next = D_DONE;
        end
      end

      // A flush seen at any point of the fetch (including the ack cycle)
      // marks the returning instruction as stale.
      I_BUSY: begin
        if (flush_in) begin
          drop_next = True;
        end
        if (bus.bus_ack_in) begin
          bus_req_next = ChipDisable;
          bus_we_next  = False;
          bus_sel_next = '0;
          drop_next    = False;
          if (drop_reg || flush_in) begin
            state_next = IDLE;
          end else begin
            inst_data_next = bus.bus_rdata_in;
            state_next     = I_DONE;
          end
        end
      end

      D_DONE, I_DONE: begin
        if (!stall_in || flush_in) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // While a data access is in flight a pending fetch is stalled as well.
  assign stallreq_data_out = data_ce_in && (state_reg != D_DONE);
  assign stallreq_inst_out = inst_ce_in && (state_reg != I_DONE);

  assign inst_data_out     = inst_data_reg;
  assign data_rdata_out    = data_rdata_reg;
  assign bus.bus_req_out   = bus_req_reg;
  assign bus.bus_we_out    = bus_we_reg;
  assign bus.bus_sel_out   = bus_sel_reg;
  assign bus.bus_addr_out  = bus_addr_reg;
  assign bus.bus_wdata_out = bus_wdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Scoreboard bench: stimulus pushes the expected bus transaction and the
//   expected port result into queues; a bus responder/monitor and a result
//   monitor pop and compare whenever the DUT presents them.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, flush_in;
  logic        inst_ce_in;
  logic [31:0] inst_addr_in, inst_data_out;
  logic        stallreq_inst_out;
  logic        data_ce_in, data_we_in;
  logic [3:0]  data_sel_in;
  logic [31:0] data_addr_in, data_wdata_in, data_rdata_out;
  logic        stallreq_data_out;

  logic        resp_ack, man_ack;
  logic [31:0] resp_rdata, man_rdata;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();
  assign bus_if.bus_ack_in   = resp_ack | man_ack;
  assign bus_if.bus_rdata_in = man_ack ? man_rdata : resp_rdata;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_in          (stall_in),
    .flush_in          (flush_in),
    .inst_ce_in        (inst_ce_in),
    .inst_addr_in      (inst_addr_in),
    .inst_data_out     (inst_data_out),
    .stallreq_inst_out (stallreq_inst_out),
    .data_ce_in        (data_ce_in),
    .data_we_in        (data_we_in),
    .data_sel_in       (data_sel_in),
    .data_addr_in      (data_addr_in),
    .data_wdata_in     (data_wdata_in),
    .data_rdata_out    (data_rdata_out),
    .stallreq_data_out (stallreq_data_out),
    .bus               (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } txn_t;

  txn_t        bus_q[$];
  logic [31:0] res_iq[$];
  logic [31:0] res_dq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_inst = 32'h0;
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder + bus-side monitor
  txn_t cur_t;
  bit   aborted;
  initial begin
    resp_ack   = 1'b0;
    resp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.bus_req_out) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_req", 32'd1, 32'd0);
          cur_t = '{default: 0};
        end else begin
          cur_t = bus_q.pop_front();
        end
        $display("bus txn: addr=%h we=%0d sel=%b wdata=%h rdata=%h waits=%0d",
                 bus_if.bus_addr_out, bus_if.bus_we_out, bus_if.bus_sel_out,
                 bus_if.bus_wdata_out, cur_t.rdata, cur_t.waits);
        chk("bus_addr", bus_if.bus_addr_out, cur_t.addr);
        chk("bus_we", 32'(bus_if.bus_we_out), 32'(cur_t.we));
        chk("bus_sel", 32'(bus_if.bus_sel_out), 32'(cur_t.sel));
        if (cur_t.we) chk("bus_wdata", bus_if.bus_wdata_out, cur_t.wdata);
        aborted = 1'b0;
        for (int i = 0; i < cur_t.waits; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          chk("bus_hold_req", 32'(bus_if.bus_req_out), 32'd1);
          chk("bus_hold_addr", bus_if.bus_addr_out, cur_t.addr);
        end
        if (!aborted) begin
          resp_rdata = cur_t.rdata;
          resp_ack   = 1'b1;
          @(posedge clk);
          #1 resp_ack = 1'b0;
        end
      end
    end
  end

  // Result monitor: pops on the first cycle a port is satisfied, then
  // checks the held value on every further satisfied cycle.
  bit          prev_i = 1'b0, prev_d = 1'b0;
  logic [31:0] cur_i, cur_d;
  initial begin
    forever begin
      @(negedge clk);
      if (data_ce_in && !stallreq_data_out) begin
        if (!prev_d) begin
          if (res_dq.size() == 0) begin
            chk("data_result_unexpected", 32'd1, 32'd0);
            cur_d = 32'h0;
          end else begin
            cur_d = res_dq.pop_front();
          end
        end
        chk("data_rdata", data_rdata_out, cur_d);
        prev_d = 1'b1;
      end else begin
        prev_d = 1'b0;
      end
      if (inst_ce_in && !stallreq_inst_out) begin
        if (!prev_i) begin
          if (res_iq.size() == 0) begin
            chk("inst_result_unexpected", 32'd1, 32'd0);
            cur_i = 32'h0;
          end else begin
            cur_i = res_iq.pop_front();
          end
        end
        chk("inst_data", inst_data_out, cur_i);
        prev_i = 1'b1;
      end else begin
        prev_i = 1'b0;
      end
    end
  end

  // Reference model: data wins over fetch, bus address is word aligned,
  // fetch uses all lanes, stores leave the load result untouched.
  task automatic issue(input bit do_i, input bit do_d, input bit dwe,
                       input logic [31:0] iaddr, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [3:0] dsel,
                       input logic [31:0] irdata, input logic [31:0] drdata,
                       input int iw, input int dw);
    if (do_d) begin
      bus_q.push_back('{daddr & 32'hFFFF_FFFC, dwe, dsel, dwdata, drdata, dw});
      if (dwe) begin
        res_dq.push_back(last_load);
      end else begin
        res_dq.push_back(drdata);
        last_load = drdata;
      end
    end
    if (do_i) begin
      bus_q.push_back('{iaddr & 32'hFFFF_FFFC, 1'b0, FULL_SEL, 32'h0, irdata, iw});
      res_iq.push_back(irdata);
      last_inst = irdata;
    end
    data_ce_in    = do_d;
    data_we_in    = dwe;
    data_sel_in   = dsel;
    data_addr_in  = daddr;
    data_wdata_in = dwdata;
    inst_ce_in    = do_i;
    inst_addr_in  = iaddr;
  endtask

  // Keeps requests up until each port is satisfied, holding stall_in for
  // 'hold' cycles at each completion. Returns just after the edge on which
  // the arbiter goes back to IDLE.
  task automatic run_to_done(input int hold, input int exp_lat);
    int budget;
    int cyc;
    bit first;
    int h;
    budget = 300;
    cyc    = 0;
    first  = 1'b1;
    h      = hold;
    while ((inst_ce_in || data_ce_in) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (data_ce_in && !stallreq_data_out) begin
        if (first && exp_lat >= 0) chk("latency", 32'(cyc), 32'(exp_lat));
        first = 1'b0;
        if (h > 0) begin
          stall_in = 1'b1;
          h--;
        end else begin
          stall_in = 1'b0;
          @(posedge clk);
          #1 data_ce_in = 1'b0;
          h = hold;
        end
      end else if (inst_ce_in && !stallreq_inst_out) begin
        if (first && exp_lat >= 0) chk("latency", 32'(cyc), 32'(exp_lat));
        first = 1'b0;
        if (h > 0) begin
          stall_in = 1'b1;
          h--;
        end else begin
          stall_in = 1'b0;
          @(posedge clk);
          #1 inst_ce_in = 1'b0;
          h = hold;
        end
      end else if (inst_ce_in && data_ce_in) begin
        chk("inst_stall_while_data", 32'(stallreq_inst_out), 32'd1);
      end
      cyc++;
    end
    if (budget == 0) begin
      chk("timeout", 32'd1, 32'd0);
      inst_ce_in = 1'b0;
      data_ce_in = 1'b0;
      stall_in   = 1'b0;
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!bus_if.bus_req_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus_if.bus_req_out), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(bus_if.bus_req_out), 32'd0);
    chk({tag, "_we"}, 32'(bus_if.bus_we_out), 32'd0);
    chk({tag, "_sel"}, 32'(bus_if.bus_sel_out), 32'd0);
    chk({tag, "_addr"}, bus_if.bus_addr_out, 32'd0);
    chk({tag, "_wdata"}, bus_if.bus_wdata_out, 32'd0);
    chk({tag, "_inst"}, inst_data_out, 32'd0);
    chk({tag, "_data"}, data_rdata_out, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] old_inst;
  int          kind, iw, dw;
  bit          di, dd;
  logic [3:0]  rsel;

  initial begin
    rst = 1'b1;
    stall_in = 1'b0; flush_in = 1'b0;
    inst_ce_in = 1'b0; inst_addr_in = 32'h0;
    data_ce_in = 1'b0; data_we_in = 1'b0; data_sel_in = 4'h0;
    data_addr_in = 32'h0; data_wdata_in = 32'h0;
    man_ack = 1'b0; man_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    $display("reset state checked");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait fetch
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 4'h0,
          32'h2408_0005, 32'h0, 0, 0);
    run_to_done(0, 2);
    $display("zero-wait fetch done");

    // Contention: store wins, fetch follows
    issue(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_2001, 32'h5A5A_5A5A, 4'b0100,
          32'hCAFE_0001, 32'h0, 0, 3);
    run_to_done(0, 5);
    $display("contention done");

    // Load completing under a 4-cycle stall
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3000, 32'h0, 4'hF,
          32'h0, 32'hDEAD_BEEF, 0, 1);
    run_to_done(4, 3);
    $display("hold under stall done");

    // Flush during fetch: first fetch dropped, redirected fetch served
    old_inst = last_inst;
    bus_q.push_back('{32'h0000_0400, 1'b0, FULL_SEL, 32'h0, 32'h1111_1111, 2});
    bus_q.push_back('{32'h0000_0800, 1'b0, FULL_SEL, 32'h0, 32'h0BAD_F00D, 0});
    res_iq.push_back(32'h0BAD_F00D);
    last_inst = 32'h0BAD_F00D;
    inst_ce_in = 1'b1;
    inst_addr_in = 32'h0000_0400;
    wait_req("flush_req_seen");
    flush_in = 1'b1;
    @(posedge clk);
    #1 flush_in = 1'b0;
    inst_addr_in = 32'h0000_0800;
    repeat (4) begin
      @(negedge clk);
      chk("flush_inst_hold", inst_data_out, old_inst);
      chk("flush_stallreq", 32'(stallreq_inst_out), 32'd1);
    end
    run_to_done(0, -1);
    $display("flush during fetch done");

    // Stray ack in IDLE
    @(negedge clk);
    man_rdata = 32'hFFFF_FFFF;
    man_ack = 1'b1;
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    chk("stray_inst", inst_data_out, last_inst);
    chk("stray_data", data_rdata_out, last_load);
    chk("stray_req", 32'(bus_if.bus_req_out), 32'd0);
    @(posedge clk);
    #1;
    $display("stray ack done");

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(2));
      di   = (kind != 1);
      dd   = (kind != 0);
      iw   = int'($urandom_range(3));
      dw   = int'($urandom_range(3));
      rsel = 4'($urandom_range(15, 1));
      issue(di, dd, 1'($urandom_range(1)), $urandom, $urandom, $urandom, rsel,
            $urandom, $urandom, iw, dw);
      run_to_done(int'($urandom_range(2)), 2 + (dd ? dw : iw));
      $display("random txn %0d kind=%0d done", n, kind);
    end

    // Asynchronous reset in the middle of a load
    bus_q.push_back('{32'h0000_5000, 1'b0, 4'hF, 32'h0, 32'h7777_7777, 8});
    data_ce_in = 1'b1; data_we_in = 1'b0; data_sel_in = 4'hF;
    data_addr_in = 32'h0000_5000;
    wait_req("rst_req_seen");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    last_inst = 32'h0;
    last_load = 32'h0;
    data_ce_in = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    man_rdata = 32'hFFFF_FFFF;
    man_ack = 1'b1;
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    check_all_zero("late_ack");
    @(posedge clk);
    #1;
    $display("async reset done");

    // Arbiter must be back in IDLE and fully functional
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h0, 4'h0,
          32'h1234_5678, 32'h0, 1, 0);
    run_to_done(0, 3);
    $display("post-reset fetch done");

    repeat (3) @(negedge clk);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    chk("inst_queue_empty", 32'(res_iq.size()), 32'd0);
    chk("data_queue_empty", 32'(res_dq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
